adder_tree_sequencer: RTL and testbench



---
 rtl/adder_tree_sequencer.sv | 175 +++++++++++++++++
 tb/tb_adder_tree_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_sequencer.sv
// rtl/adder_tree_sequencer.sv - time-multiplexed batch reducer on one shared adder
//
// Purpose: accumulates a stream of unsigned operands into one widened sum per
// batch. A batch ends on the operand flagged in_last or when NUM_OPERANDS
// operands have been accepted. The sum is then held on the output handshake
// until the consumer takes it.
//
// Optional feature (macro ADDER_SEQ_INPUT_REG_EN): operands are staged in a
// register before the adder. This adds one DRAIN cycle per batch.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous active-high reset
//   in_valid   in   operand valid
//   in_ready   out  operand accepted when in_valid && in_ready
//   in_data    in   unsigned operand, ADDER_WIDTH bits
//   in_last    in   final operand of the batch
//   out_valid  out  batch sum available
//   out_ready  in   consumer accepts sum when out_valid && out_ready
//   out_sum    out  batch sum, ADDER_WIDTH+SUM_EXTRA_BITS bits
//   out_count  out  operands summed in the batch, SUM_EXTRA_BITS+1 bits
module adder_tree_sequencer #(
  parameter int ADDER_WIDTH    = 64,
  parameter int NUM_OPERANDS   = 8,
  parameter int SUM_EXTRA_BITS = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ADDER_WIDTH-1:0]                in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ADDER_WIDTH+SUM_EXTRA_BITS-1:0] out_sum,
  output logic [SUM_EXTRA_BITS:0]               out_count
);

  localparam int SW = ADDER_WIDTH + SUM_EXTRA_BITS;
  localparam int CW = SUM_EXTRA_BITS + 1;
  localparam logic [CW-1:0] NUM_OPS_C = CW'(NUM_OPERANDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_inc;

  assign count_inc = count_q + CW'(1);

`ifdef ADDER_SEQ_INPUT_REG_EN
  logic [ADDER_WIDTH-1:0] stage_q, stage_d;
  logic                   stage_vld_q, stage_vld_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    stage_d     = stage_q;
    stage_vld_d = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    // The staged operand is folded in one cycle after its accept, whatever
    // state we move to; this is what the DRAIN cycle waits for.
    if (stage_vld_q) begin
      acc_d = acc_q + {{SUM_EXTRA_BITS{1'b0}}, stage_q};
    end

    case (state_q)
      S_IDLE, S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          stage_d     = in_data;
          stage_vld_d = 1'b1;
          count_d     = count_inc;
          if (in_last || (count_inc == NUM_OPS_C)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
    end
  end
`else
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE, S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // acc is zero in IDLE, so the first operand needs no special case.
          acc_d   = acc_q + {{SUM_EXTRA_BITS{1'b0}}, in_data};
          count_d = count_inc;
          if (in_last || (count_inc == NUM_OPS_C)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
`endif

  // Partial sums stay hidden; the outputs read zero outside DONE.
  assign out_sum   = out_valid ? acc_q   : '0;
  assign out_count = out_valid ? count_q : '0;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// tb/tb_adder_tree_sequencer.sv - randomized self-checking bench for adder_tree_sequencer
module tb_adder_tree_sequencer;

  localparam int AW = 64;
  localparam int XB = 3;
  localparam int SW = AW + XB;
  localparam int NOPS = 8;
`ifdef ADDER_SEQ_INPUT_REG_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [XB:0]   out_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] ops_q[$];

  adder_tree_sequencer #(
    .ADDER_WIDTH(AW),
    .NUM_OPERANDS(NOPS),
    .SUM_EXTRA_BITS(XB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand after an idle gap and returns just after the accepting edge.
  task automatic send_op(input logic [AW-1:0] d, input logic last, input int gap);
    int w;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) tick();
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) check_eq("accept_timeout", 0, 1);
    else tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends ops_q as one batch, then checks latency, result, backpressure hold and handoff.
  // gap < 0 picks a random gap of 0..2 idle cycles before each operand.
  task automatic run_batch(input bit last_on_final, input int gap, input int hold,
                           input logic [SW-1:0] exp_sum, input logic [XB:0] exp_cnt);
    int k;
    int n;
    n = ops_q.size();
    for (int i = 0; i < n; i++) begin
      send_op(ops_q[i], last_on_final && (i == n - 1), (gap < 0) ? $urandom_range(0, 2) : gap);
    end
    check_eq("ready_low_after_final", in_ready, 0);
    k = 0;
    while (!out_valid && k < 6) begin
      check_eq("ready_low_drain", in_ready, 0);
      tick();
      k++;
    end
    check_eq("latency", k, LAT_EXTRA);
    check_eq("sum", out_sum, exp_sum);
    check_eq("count", out_count, exp_cnt);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = $urandom_range(0, 1);
      in_data  = {$urandom, $urandom};
      in_last  = $urandom_range(0, 1);
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_sum", out_sum, exp_sum);
      check_eq("hold_count", out_count, exp_cnt);
      check_eq("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_xfer_valid", out_valid, 0);
    check_eq("post_xfer_ready", in_ready, 1);
  endtask

  initial begin
    logic [SW-1:0] exp_sum;
    logic [AW-1:0] d;
    int            len;
    bit            last_f;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("reset_valid", out_valid, 0);
    reset = 1'b0;
    tick();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_count", out_count, 0);

    // Full batch 1..8 back-to-back, ended by the operand limit.
    ops_q.delete();
    for (int i = 1; i <= 8; i++) ops_q.push_back(AW'(i));
    run_batch(1'b0, 0, 0, SW'(36), 4'd8);

    // Eight all-ones operands must not wrap.
    ops_q.delete();
    for (int i = 0; i < 8; i++) ops_q.push_back({AW{1'b1}});
    run_batch(1'b0, 0, 0, 67'h7_FFFF_FFFF_FFFF_FFF8, 4'd8);

    // Early termination.
    ops_q.delete();
    ops_q.push_back(AW'(10));
    ops_q.push_back(AW'(20));
    ops_q.push_back(AW'(30));
    run_batch(1'b1, 0, 0, SW'(60), 4'd3);

    // Backpressure with ignored in_valid pulses.
    ops_q.delete();
    ops_q.push_back(AW'(100));
    ops_q.push_back(AW'(23));
    run_batch(1'b1, 0, 5, SW'(123), 4'd2);

    // Input gaps.
    ops_q.delete();
    ops_q.push_back(AW'(5));
    ops_q.push_back(AW'(7));
    run_batch(1'b1, 1, 0, SW'(12), 4'd2);

    // Single-operand batch.
    ops_q.delete();
    ops_q.push_back(AW'(42));
    run_batch(1'b1, 0, 1, SW'(42), 4'd1);

    // Reset in the middle of a batch discards it.
    for (int i = 0; i < 4; i++) send_op(AW'(1000 + i), 1'b0, 0);
    reset = 1'b1;
    tick();
    check_eq("midrst_valid_during", out_valid, 0);
    check_eq("midrst_sum_during", out_sum, 0);
    reset = 1'b0;
    tick();
    check_eq("midrst_valid_after", out_valid, 0);
    check_eq("midrst_count_after", out_count, 0);
    check_eq("midrst_ready_after", in_ready, 1);
    ops_q.delete();
    ops_q.push_back(AW'(2));
    ops_q.push_back(AW'(2));
    run_batch(1'b1, 0, 0, SW'(4), 4'd2);

    // Randomized batches against a plain-sum reference.
    for (int b = 0; b < 40; b++) begin
      ops_q.delete();
      len     = $urandom_range(1, NOPS);
      exp_sum = '0;
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : {$urandom, $urandom};
        ops_q.push_back(d);
        exp_sum = exp_sum + SW'(d);
      end
      last_f = (len < NOPS) ? 1'b1 : 1'($urandom_range(0, 1));
      run_batch(last_f, -1, $urandom_range(0, 3), exp_sum, (XB + 1)'(len));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
